// File: rtl/term_write_ctrl.sv
// term_write_ctrl
// Write-side sequencer for an 80x60 monochrome character buffer. It consumes
// terminal bytes (printables and control codes), tracks the cursor and drives
// port A of the dual-port char RAM. It also handles full-screen clears and
// hardware scrolling. A scroll blanks the oldest physical row and advances
// top_row. The renderer adds top_row to its row index, so no data is copied.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   i_in_valid/i_in_data  input byte stream
//   o_in_ready            byte accepted this cycle when valid & ready
//   i_clear_req           level request for a full-screen clear
//   o_ram_ce/o_ram_wre    registered write strobe (identical)
//   o_ram_ad/o_ram_din    registered write address / data
//   o_cursor_col/row      logical cursor position
//   o_top_row             physical RAM row displayed as screen row 0
//   o_busy                high while clearing or scrolling
module term_write_ctrl #(
  parameter int         COLS   = 80,
  parameter int         ROWS   = 60,
  parameter int         ADDR_W = 13,
  parameter logic [7:0] BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  input  logic              i_clear_req,
  output logic              o_ram_ce,
  output logic              o_ram_wre,
  output logic [ADDR_W-1:0] o_ram_ad,
  output logic [7:0]        o_ram_din,
  output logic [6:0]        o_cursor_col,
  output logic [5:0]        o_cursor_row,
  output logic [5:0]        o_top_row,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] CELLS = ADDR_W'(COLS * ROWS);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_SCRL, S_CLR_ALL} state_t;

  state_t              r_state, w_stateNxt;
  logic [6:0]          r_col, w_colNxt;
  logic [5:0]          r_row, w_rowNxt;
  logic [5:0]          r_top, w_topNxt;
  // Shared counter: column index during a scroll, next address during a clear.
  logic [ADDR_W-1:0]   r_cnt, w_cntNxt;
  logic                r_ce, w_ceNxt;
  logic [ADDR_W-1:0]   r_ad, w_adNxt;
  logic [7:0]          r_din, w_dinNxt;

  logic                w_newline;
  logic                w_clrStart;
  logic [6:0]          w_prowSum;
  logic [5:0]          w_prow;
  logic [ADDR_W-1:0]   w_curAddr;
  logic [ADDR_W-1:0]   w_topBase;
  logic                w_printable;

  // Logical row maps to a physical row by rotating with top_row (mod ROWS).
  assign w_prowSum   = {1'b0, r_top} + {1'b0, r_row};
  assign w_prow      = (w_prowSum >= 7'(ROWS)) ? 6'(w_prowSum - 7'(ROWS)) : w_prowSum[5:0];
  assign w_curAddr   = ADDR_W'(w_prow) * ADDR_W'(COLS) + ADDR_W'(r_col);
  assign w_topBase   = ADDR_W'(r_top) * ADDR_W'(COLS);
  assign w_printable = (i_in_data >= 8'h20) && (i_in_data <= 8'h7E);

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLR_ALL;
      r_col   <= '0;
      r_row   <= '0;
      r_top   <= '0;
      r_cnt   <= '0;
      r_ce    <= 1'b0;
      r_ad    <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_stateNxt;
      r_col   <= w_colNxt;
      r_row   <= w_rowNxt;
      r_top   <= w_topNxt;
      r_cnt   <= w_cntNxt;
      r_ce    <= w_ceNxt;
      r_ad    <= w_adNxt;
      r_din   <= w_dinNxt;
    end
  end

  // Next-state and next-datapath logic. Newline and clear-start are shared
  // by several paths, so they are raised as flags and resolved after the case.
  always_comb begin
    w_stateNxt = r_state;
    w_colNxt   = r_col;
    w_rowNxt   = r_row;
    w_topNxt   = r_top;
    w_cntNxt   = r_cnt;
    w_ceNxt    = 1'b0;
    w_adNxt    = r_ad;
    w_dinNxt   = r_din;
    w_newline  = 1'b0;
    w_clrStart = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_clear_req) begin
          w_clrStart = 1'b1;
        end else if (i_in_valid) begin
          if (w_printable) begin
            w_stateNxt = S_WR;
            w_ceNxt    = 1'b1;
            w_adNxt    = w_curAddr;
            w_dinNxt   = i_in_data;
          end else begin
            case (i_in_data)
              8'h0A: w_newline = 1'b1;
              8'h0D: w_colNxt = '0;
              8'h08: if (r_col != '0) w_colNxt = r_col - 7'd1;
              8'h0C: w_clrStart = 1'b1;
              default: ;
            endcase
          end
        end
      end

      S_WR: begin
        if (r_col < 7'(COLS - 1)) begin
          w_colNxt   = r_col + 7'd1;
          w_stateNxt = S_IDLE;
        end else begin
          w_colNxt  = '0;
          w_newline = 1'b1;
        end
      end

      S_SCRL: begin
        if (r_cnt < ADDR_W'(COLS - 1)) begin
          w_cntNxt = r_cnt + 1'b1;
          w_ceNxt  = 1'b1;
          w_adNxt  = r_ad + 1'b1;
          w_dinNxt = BLANK;
        end else begin
          w_stateNxt = S_IDLE;
          w_topNxt   = (r_top == 6'(ROWS - 1)) ? 6'd0 : r_top + 6'd1;
          w_colNxt   = '0;
        end
      end

      S_CLR_ALL: begin
        if (r_cnt < CELLS) begin
          w_ceNxt  = 1'b1;
          w_adNxt  = r_cnt;
          w_dinNxt = BLANK;
          w_cntNxt = r_cnt + 1'b1;
        end else begin
          w_stateNxt = S_IDLE;
        end
      end
    endcase

    // At the last row a newline starts a scroll of the oldest physical row;
    // the first blank write is issued on the same edge.
    if (w_newline) begin
      if (r_row < 6'(ROWS - 1)) begin
        w_rowNxt   = r_row + 6'd1;
        w_stateNxt = S_IDLE;
      end else begin
        w_stateNxt = S_SCRL;
        w_cntNxt   = '0;
        w_ceNxt    = 1'b1;
        w_adNxt    = w_topBase;
        w_dinNxt   = BLANK;
      end
    end

    if (w_clrStart) begin
      w_stateNxt = S_CLR_ALL;
      w_colNxt   = '0;
      w_rowNxt   = '0;
      w_topNxt   = '0;
      w_cntNxt   = '0;
      w_ceNxt    = 1'b0;
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    o_in_ready = (r_state == S_IDLE) && !i_clear_req;
    o_busy     = (r_state == S_SCRL) || (r_state == S_CLR_ALL);
  end

  assign o_ram_ce     = r_ce;
  assign o_ram_wre    = r_ce;
  assign o_ram_ad     = r_ad;
  assign o_ram_din    = r_din;
  assign o_cursor_col = r_col;
  assign o_cursor_row = r_row;
  assign o_top_row    = r_top;

endmodule

// File: tb/tb_term_write_ctrl.sv
// tb_term_write_ctrl
// Scoreboard bench for term_write_ctrl. Stimulus pushes every expected RAM
// write into a queue; an independent monitor pops and compares on each strobe.
// Cursor, top_row and handshake values are checked against hand-computed
// constants at specific points in the sequence.
module tb_term_write_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic [7:0]  inData;
  logic        inReady;
  logic        clearReq;
  logic        ramCe;
  logic        ramWre;
  logic [12:0] ramAd;
  logic [7:0]  ramDin;
  logic [6:0]  cursorCol;
  logic [5:0]  cursorRow;
  logic [5:0]  topRow;
  logic        busy;

  typedef struct packed {
    logic [12:0] ad;
    logic [7:0]  din;
    logic        busy;
  } wrExp_t;

  wrExp_t expQ[$];
  int     numChecks = 0;
  int     numPassed = 0;

  term_write_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (inValid),
    .i_in_data    (inData),
    .o_in_ready   (inReady),
    .i_clear_req  (clearReq),
    .o_ram_ce     (ramCe),
    .o_ram_wre    (ramWre),
    .o_ram_ad     (ramAd),
    .o_ram_din    (ramDin),
    .o_cursor_col (cursorCol),
    .o_cursor_row (cursorRow),
    .o_top_row    (topRow),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d", numPassed, numChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: every write strobe must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ramCe === 1'b1) begin
      wrExp_t e;
      numChecks++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpectedWrite: got ad=%0d din=%02h, expected no write", ramAd, ramDin);
      end else begin
        e = expQ.pop_front();
        if (ramWre === 1'b1 && ramAd === e.ad && ramDin === e.din && busy === e.busy)
          numPassed++;
        else
          $display("[TB] FAIL ramWrite: got ad=%0d din=%02h wre=%b busy=%b, expected ad=%0d din=%02h wre=1 busy=%b",
                   ramAd, ramDin, ramWre, busy, e.ad, e.din, e.busy);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    numChecks++;
    if (actual == expected) numPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c);
    inValid  = v;
    inData   = d;
    clearReq = c;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pushWrite(input int ad, input logic [7:0] din, input logic b);
    wrExp_t e;
    e.ad   = 13'(ad);
    e.din  = din;
    e.busy = b;
    expQ.push_back(e);
  endtask

  task automatic pushClearAll();
    for (int i = 0; i < 4800; i++) pushWrite(i, 8'h20, 1'b1);
  endtask

  task automatic pushScroll(input int top);
    for (int c = 0; c < 80; c++) pushWrite(top * 80 + c, 8'h20, 1'b1);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (inReady !== 1'b1 && n < maxCycles) begin
      tick();
      n++;
    end
    numChecks++;
    if (inReady === 1'b1) numPassed++;
    else $display("[TB] FAIL idleTimeout: in_ready still %b after %0d cycles, expected 1", inReady, maxCycles);
  endtask

  // Printable byte: expected write at ad, optionally followed by a scroll of
  // physical row scrollTop (when the byte wraps past the last row).
  task automatic sendPrintable(input logic [7:0] b, input int ad, input int scrollTop);
    pushWrite(ad, b, 1'b0);
    if (scrollTop >= 0) pushScroll(scrollTop);
    applyStimulus(1'b1, b, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
  endtask

  task automatic sendCtrl(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".ce"}, int'(ramCe), 0);
    checkOutput({tag, ".wre"}, int'(ramWre), 0);
    checkOutput({tag, ".ad"}, int'(ramAd), 0);
    checkOutput({tag, ".din"}, int'(ramDin), 0);
    checkOutput({tag, ".inReady"}, int'(inReady), 0);
    checkOutput({tag, ".busy"}, int'(busy), 1);
    checkOutput({tag, ".col"}, int'(cursorCol), 0);
    checkOutput({tag, ".row"}, int'(cursorRow), 0);
    checkOutput({tag, ".top"}, int'(topRow), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    checkResetValues("reset");

    // Power-on clear: 4800 blank writes, then idle at (0,0), top 0.
    pushClearAll();
    rst_n = 1'b1;
    waitIdle(6000);
    checkOutput("powerOn.queueEmpty", expQ.size(), 0);
    checkOutput("powerOn.col", int'(cursorCol), 0);
    checkOutput("powerOn.row", int'(cursorRow), 0);
    checkOutput("powerOn.top", int'(topRow), 0);

    // Single printable: WR cycle after acceptance, idle two cycles after.
    pushWrite(0, 8'h41, 1'b0);
    applyStimulus(1'b1, 8'h41, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("wr.inReadyLow", int'(inReady), 0);
    tick();
    checkOutput("wr.inReadyBack", int'(inReady), 1);
    checkOutput("wr.col", int'(cursorCol), 1);

    // 80 printables from (0,0): wrap to row 1 without any blank writes.
    sendCtrl(8'h0D);
    for (int i = 0; i < 80; i++) sendPrintable(8'h61 + 8'(i % 26), i, -1);
    checkOutput("line.col", int'(cursorCol), 0);
    checkOutput("line.row", int'(cursorRow), 1);
    checkOutput("line.top", int'(topRow), 0);

    // Backspace / CR / BEL at col 5 (row 1: addresses 80..84).
    for (int i = 0; i < 5; i++) sendPrintable(8'h30 + 8'(i), 80 + i, -1);
    sendCtrl(8'h08);
    checkOutput("bs1.col", int'(cursorCol), 4);
    checkOutput("bs1.inReady", int'(inReady), 1);
    sendCtrl(8'h0D);
    checkOutput("cr.col", int'(cursorCol), 0);
    sendCtrl(8'h08);
    checkOutput("bs0.col", int'(cursorCol), 0);
    sendCtrl(8'h07);
    checkOutput("bel.col", int'(cursorCol), 0);
    checkOutput("bel.inReady", int'(inReady), 1);

    // Walk down to row 59, then LF scrolls physical row 0.
    for (int i = 0; i < 58; i++) sendCtrl(8'h0A);
    checkOutput("lf.row", int'(cursorRow), 59);
    pushScroll(0);
    sendCtrl(8'h0A);
    checkOutput("scrl.busy", int'(busy), 1);
    checkOutput("scrl.inReady", int'(inReady), 0);
    waitIdle(200);
    checkOutput("scrl.queueEmpty", expQ.size(), 0);
    checkOutput("scrl.top", int'(topRow), 1);
    checkOutput("scrl.row", int'(cursorRow), 59);
    checkOutput("scrl.col", int'(cursorCol), 0);
    // prow = (1 + 59) mod 60 = 0.
    sendPrintable(8'h42, 0, -1);
    checkOutput("afterScrl.col", int'(cursorCol), 1);

    // Fill the rest of the bottom line; the wrap triggers a scroll of row 1.
    for (int c = 1; c < 80; c++) begin
      sendPrintable(8'h50, c, (c == 79) ? 1 : -1);
      if (c == 79) waitIdle(200);
    end
    checkOutput("wrapScrl.top", int'(topRow), 2);
    checkOutput("wrapScrl.row", int'(cursorRow), 59);
    checkOutput("wrapScrl.col", int'(cursorCol), 0);

    // 58 more scrolls: top_row walks 2..59 and wraps to 0.
    for (int k = 0; k < 58; k++) begin
      pushScroll(2 + k);
      sendCtrl(8'h0A);
      waitIdle(200);
    end
    checkOutput("topWrap.top", int'(topRow), 0);
    checkOutput("topWrap.queueEmpty", expQ.size(), 0);
    sendPrintable(8'h44, 4720, -1);
    checkOutput("lastRow.col", int'(cursorCol), 1);

    // clear_req wins over a simultaneous valid byte.
    applyStimulus(1'b1, 8'h43, 1'b1);
    #1;
    checkOutput("clr.inReadyLow", int'(inReady), 0);
    pushClearAll();
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("clr.busy", int'(busy), 1);
    checkOutput("clr.top", int'(topRow), 0);
    waitIdle(6000);
    checkOutput("clr.queueEmpty", expQ.size(), 0);
    checkOutput("clr.col", int'(cursorCol), 0);
    checkOutput("clr.row", int'(cursorRow), 0);
    sendPrintable(8'h43, 0, -1);

    // Reset in the middle of a scroll aborts and restarts the clear at 0.
    sendCtrl(8'h0D);
    for (int i = 0; i < 59; i++) sendCtrl(8'h0A);
    checkOutput("preAbort.row", int'(cursorRow), 59);
    pushScroll(0);
    sendCtrl(8'h0A);
    repeat (9) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("abort");
    expQ.delete();
    pushClearAll();
    tick();
    rst_n = 1'b1;
    waitIdle(6000);
    checkOutput("restart.queueEmpty", expQ.size(), 0);
    checkOutput("restart.inReady", int'(inReady), 1);

    tick();
    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
